// File: rtl/decode_stage.sv
// Single-cycle instruction decode register with optional load-use hazard detection.
// Build option: define DECODE_HAZARD_EN to enable load-use stall generation.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_code,
    input  logic [31:0] old_pc,
    input  logic        flush,
    output logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [31:0] id_imm,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_alu_src,
    output logic        id_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        illegal;
    } id_t;

    id_t  dec_s;
    id_t  id_d;
    id_t  id_q;
    logic hazard_s;
    logic reg_write_raw_s;

    // Combinational decode of the incoming instruction word
    always_comb begin
        dec_s           = '0;
        reg_write_raw_s = 1'b0;
        dec_s.valid     = 1'b1;
        dec_s.pc        = old_pc;
        dec_s.opcode    = instruction_code[6:0];
        dec_s.rd        = instruction_code[11:7];
        dec_s.funct3    = instruction_code[14:12];
        dec_s.rs1       = instruction_code[19:15];
        dec_s.rs2       = instruction_code[24:20];
        dec_s.funct7    = instruction_code[31:25];
        case (instruction_code[6:0])
            OP_R: begin
                reg_write_raw_s = 1'b1;
            end
            OP_IALU, OP_LOAD, OP_JALR: begin
                reg_write_raw_s = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.mem_read  = (instruction_code[6:0] == OP_LOAD);
                dec_s.jump      = (instruction_code[6:0] == OP_JALR);
                dec_s.imm       = {{20{instruction_code[31]}}, instruction_code[31:20]};
            end
            OP_STORE: begin
                dec_s.mem_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.imm       = {{20{instruction_code[31]}}, instruction_code[31:25],
                                   instruction_code[11:7]};
            end
            OP_BRANCH: begin
                dec_s.branch = 1'b1;
                dec_s.imm    = {{19{instruction_code[31]}}, instruction_code[31], instruction_code[7],
                                instruction_code[30:25], instruction_code[11:8], 1'b0};
            end
            OP_JAL: begin
                reg_write_raw_s = 1'b1;
                dec_s.jump      = 1'b1;
                dec_s.imm       = {{11{instruction_code[31]}}, instruction_code[31],
                                   instruction_code[19:12], instruction_code[20],
                                   instruction_code[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                reg_write_raw_s = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.imm       = {instruction_code[31:12], 12'h000};
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
        // x0 is hardwired, so a write to it is never a real write
        dec_s.reg_write = reg_write_raw_s & (instruction_code[11:7] != 5'd0);
    end

`ifdef DECODE_HAZARD_EN
    logic uses_rs1_s;
    logic uses_rs2_s;

    // Which source register fields the incoming instruction actually reads
    always_comb begin
        uses_rs1_s = 1'b0;
        uses_rs2_s = 1'b0;
        case (instruction_code[6:0])
            OP_R, OP_STORE, OP_BRANCH: begin
                uses_rs1_s = 1'b1;
                uses_rs2_s = 1'b1;
            end
            OP_IALU, OP_LOAD, OP_JALR: begin
                uses_rs1_s = 1'b1;
            end
            default: begin
                uses_rs1_s = 1'b0;
                uses_rs2_s = 1'b0;
            end
        endcase
    end

    // Load-use detection against the instruction currently in the register
    always_comb begin
        hazard_s = 1'b0;
        if (id_q.valid && id_q.mem_read && (id_q.rd != 5'd0) && !flush) begin
            hazard_s = (uses_rs1_s && (dec_s.rs1 == id_q.rd)) ||
                       (uses_rs2_s && (dec_s.rs2 == id_q.rd));
        end else begin
            hazard_s = 1'b0;
        end
    end
`else
    assign hazard_s = 1'b0;
`endif

    assign stall = hazard_s;

    // Next register contents: bubble on flush or hazard, decoded word otherwise
    always_comb begin
        id_d = '0;
        if (!flush && !hazard_s) begin
            id_d = dec_s;
        end else begin
            id_d = '0;
        end
    end

    // Stage register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

    assign id_valid     = id_q.valid;
    assign id_pc        = id_q.pc;
    assign id_opcode    = id_q.opcode;
    assign id_rd        = id_q.rd;
    assign id_rs1       = id_q.rs1;
    assign id_rs2       = id_q.rs2;
    assign id_funct3    = id_q.funct3;
    assign id_funct7    = id_q.funct7;
    assign id_imm       = id_q.imm;
    assign id_reg_write = id_q.reg_write;
    assign id_mem_read  = id_q.mem_read;
    assign id_mem_write = id_q.mem_write;
    assign id_branch    = id_q.branch;
    assign id_jump      = id_q.jump;
    assign id_alu_src   = id_q.alu_src;
    assign id_illegal   = id_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hazard/flush/reset
// sequences, and randomized stimulus against a reference decoder model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_code;
    logic [31:0] old_pc;
    logic        flush;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [31:0] id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src, id_illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .instruction_code(instruction_code), .old_pc(old_pc),
        .flush(flush), .stall(stall), .id_valid(id_valid), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_alu_src(id_alu_src), .id_illegal(id_illegal)
    );

`ifdef DECODE_HAZARD_EN
    localparam logic HAZ_ON = 1'b1;
`else
    localparam logic HAZ_ON = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        rw, mr, mw, br, jp, as, ill;
    } dec_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  ctl;   // {rw, mr, mw, br, jp, as, ill}
    } vec_t;

    dec_t dut_s;
    assign dut_s = {id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_funct7,
                    id_imm, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump,
                    id_alu_src, id_illegal};

    int   n_tests = 0;
    int   n_fail  = 0;
    dec_t model_q = '0;
    logic model_known = 1'b0;
    logic last_stall;
    logic last_exp_stall = 1'b0;
    dec_t last_out;

    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        dec_t r;
        byte  fmt;
        logic [11:0] s12;
        logic [12:0] b13;
        logic [20:0] j21;
        r = '0;
        r.valid = 1'b1; r.pc = pc; r.op = ins[6:0]; r.rd = ins[11:7];
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.f3 = ins[14:12]; r.f7 = ins[31:25];
        case (ins[6:0])
            7'b0110011: begin fmt = "R"; r.rw = 1'b1; end
            7'b0010011: begin fmt = "I"; r.rw = 1'b1; r.as = 1'b1; end
            7'b0000011: begin fmt = "I"; r.rw = 1'b1; r.mr = 1'b1; r.as = 1'b1; end
            7'b0100011: begin fmt = "S"; r.mw = 1'b1; r.as = 1'b1; end
            7'b1100011: begin fmt = "B"; r.br = 1'b1; end
            7'b1101111: begin fmt = "J"; r.rw = 1'b1; r.jp = 1'b1; end
            7'b1100111: begin fmt = "I"; r.rw = 1'b1; r.jp = 1'b1; r.as = 1'b1; end
            7'b0110111: begin fmt = "U"; r.rw = 1'b1; r.as = 1'b1; end
            7'b0010111: begin fmt = "U"; r.rw = 1'b1; r.as = 1'b1; end
            default:    begin fmt = "X"; r.ill = 1'b1; end
        endcase
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (fmt)
            "I":     r.imm = 32'($signed(ins[31:20]));
            "S":     r.imm = 32'($signed(s12));
            "B":     r.imm = 32'($signed(b13));
            "J":     r.imm = 32'($signed(j21));
            "U":     r.imm = {ins[31:12], 12'h000};
            default: r.imm = 32'd0;
        endcase
        r.rw = r.rw && (r.rd != 5'd0);
        return r;
    endfunction

    function automatic logic ref_stall(input dec_t cur, input logic [31:0] ins, input logic fl);
        logic [6:0] op;
        logic u1, u2;
        op = ins[6:0];
        u1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return HAZ_ON && cur.valid && cur.mr && (cur.rd != 5'd0) && !fl &&
               ((u1 && ins[19:15] == cur.rd) || (u2 && ins[24:20] == cur.rd));
    endfunction

    task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, check stall before the edge, outputs after it
    task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                         input logic rv, input string nm);
        logic exp_st;
        instruction_code = ins; old_pc = pc; flush = fl; reset = rv;
        #1;
        exp_st = ref_stall(model_q, ins, fl);
        last_stall = stall;
        last_exp_stall = exp_st;
        if (model_known) chk({nm, "_stall"}, 104'(stall), 104'(exp_st));
        if (!rv || fl || exp_st) model_q = '0;
        else                     model_q = ref_decode(ins, pc);
        model_known = 1'b1;
        @(posedge clk);
        #1;
        last_out = dut_s;
        chk({nm, "_out"}, dut_s, model_q);
        @(negedge clk);
    endtask

    vec_t vecs[11];
    logic [6:0] ops[10];

    initial begin
        logic [31:0] ins, pc;
        logic        fl, rv;
        vecs[0]  = '{32'h00500093, 32'h00000005, 5'd1,  7'b1000010};  // addi x1,x0,5
        vecs[1]  = '{32'hFE000CE3, 32'hFFFFFFF8, 5'd25, 7'b0001000};  // beq x0,x0,-8
        vecs[2]  = '{32'h0000007F, 32'h00000000, 5'd0,  7'b0000001};  // illegal
        vecs[3]  = '{32'h0000A103, 32'h00000000, 5'd2,  7'b1100010};  // lw x2,0(x1)
        vecs[4]  = '{32'h123452B7, 32'h12345000, 5'd5,  7'b1000010};  // lui x5
        vecs[5]  = '{32'h008000EF, 32'h00000008, 5'd1,  7'b1000100};  // jal x1,8
        vecs[6]  = '{32'h0020A223, 32'h00000004, 5'd4,  7'b0010010};  // sw x2,4(x1)
        vecs[7]  = '{32'h00008067, 32'h00000000, 5'd0,  7'b0000110};  // jalr x0,0(x1)
        vecs[8]  = '{32'h00001197, 32'h00001000, 5'd3,  7'b1000010};  // auipc x3,1
        vecs[9]  = '{32'h002101B3, 32'h00000000, 5'd3,  7'b1000000};  // add x3,x2,x2
        vecs[10] = '{32'hFFF00213, 32'hFFFFFFFF, 5'd4,  7'b1000010};  // addi x4,x0,-1
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

        cycle(32'h00500093, 32'h0, 1'b0, 1'b0, "reset0");
        cycle(32'h00500093, 32'h0, 1'b0, 1'b0, "reset1");
        chk("reset_zero", last_out, 104'd0);

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].ins, 32'(i * 4), 1'b0, 1'b1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_fields", i),
                104'({last_out.valid, last_out.rd, last_out.imm, last_out.rw, last_out.mr,
                      last_out.mw, last_out.br, last_out.jp, last_out.as, last_out.ill}),
                104'({1'b1, vecs[i].rd, vecs[i].imm, vecs[i].ctl}));
        end

        // Load-use: lw x2 then add x3,x2,x2
        cycle(32'h0000A103, 32'h100, 1'b0, 1'b1, "luse_lw");
        cycle(32'h002101B3, 32'h104, 1'b0, 1'b1, "luse_add");
        chk("luse_stall", 104'(last_stall), 104'(HAZ_ON));
        chk("luse_valid", 104'(last_out.valid), 104'(!HAZ_ON));
`ifdef DECODE_HAZARD_EN
        cycle(32'h002101B3, 32'h104, 1'b0, 1'b1, "luse_hold");
        chk("luse_stall_once", 104'(last_stall), 104'd0);
`endif
        chk("luse_pc", 104'({last_out.valid, last_out.pc}), 104'({1'b1, 32'h104}));

        // Flush wins over the hazard
        cycle(32'h0000A103, 32'h300, 1'b0, 1'b1, "fl_lw");
        cycle(32'h002101B3, 32'h304, 1'b1, 1'b1, "fl_add");
        chk("fl_stall", 104'(last_stall), 104'd0);
        chk("fl_bubble", 104'(last_out.valid), 104'd0);
        cycle(32'h002101B3, 32'h308, 1'b0, 1'b1, "fl_next");

        // Load to x0 never creates a hazard
        cycle(32'h0000A003, 32'h400, 1'b0, 1'b1, "x0_lw");
        cycle(32'h000001B3, 32'h404, 1'b0, 1'b1, "x0_add");
        chk("x0_stall", 104'(last_stall), 104'd0);
        chk("x0_valid", 104'(last_out.valid), 104'd1);

        // Reset during a stall cycle
        cycle(32'h0000A103, 32'h500, 1'b0, 1'b1, "rs_lw");
        cycle(32'h002101B3, 32'h504, 1'b0, 1'b0, "rs_add");
        chk("rs_stall_in", 104'(last_stall), 104'(HAZ_ON));
        chk("rs_zero", last_out, 104'd0);
        cycle(32'h002101B3, 32'h504, 1'b0, 1'b1, "rs_after");
        chk("rs_stall_after", 104'(last_stall), 104'd0);
        chk("rs_pc", 104'({last_out.valid, last_out.pc}), 104'({1'b1, 32'h504}));

        // Randomized stream; fetch holds the instruction while a stall is expected
        pc  = 32'h1000;
        ins = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (!(last_exp_stall && i > 0)) begin
                ins = $urandom;
                ins[6:0]   = ops[$urandom_range(0, 9)];
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                pc = pc + 32'd4;
            end
            fl = ($urandom_range(0, 9) == 0);
            rv = ($urandom_range(0, 49) != 0);
            cycle(ins, pc, fl, rv, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
